// File: rtl/ir_pkg.sv
// ir_pkg: NEC frame field positions and sequencer state encoding
package ir_pkg;
  localparam int IR_ADDR_MSB  = 31;
  localparam int IR_ADDR_LSB  = 24;
  localparam int IR_NADDR_MSB = 23;
  localparam int IR_NADDR_LSB = 16;
  localparam int IR_CMD_MSB   = 15;
  localparam int IR_CMD_LSB   = 8;
  localparam int IR_NCMD_MSB  = 7;
  localparam int IR_NCMD_LSB  = 0;
  typedef enum logic [1:0] {IDLE, ACTIVE, SWAP} ir_seq_state_t;
endpackage

// File: rtl/ir_cmd_sequencer_if.sv
// ir_cmd_sequencer_if: raw frames in from the decoder, clean key events out to consumers
interface ir_cmd_sequencer_if;
  logic [31:0] code;
  logic        newCode;
  logic [7:0]  addr;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic        press;
  logic        key_release;
  logic        hold;
  logic [7:0]  rpt_count;
  logic        err;
  logic        active;
  modport master (output code, newCode,
                  input addr, cmd, cmd_valid, press, key_release, hold, rpt_count, err, active);
  modport slave  (input code, newCode,
                  output addr, cmd, cmd_valid, press, key_release, hold, rpt_count, err, active);
endinterface

// File: rtl/ir_timeout_timer.sv
// ir_timeout_timer: reloadable down-counter; expired marks the cycle it runs out
module ir_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (!nrst) count <= '0;
    else if (load) count <= W'(TIMEOUT_CYCLES);
    else if (en && count != '0) count <= count - W'(1);
  // flags the cycle whose decrement reaches zero so release lands exactly TIMEOUT_CYCLES after the last frame
  assign expired = count <= W'(1);
endmodule

// File: rtl/ir_cmd_sequencer.sv
// ir_cmd_sequencer: turns checked NEC frames into press/hold/release key events
module ir_cmd_sequencer
  import ir_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 12_000_000,
  parameter int         HOLD_REPEATS   = 3,
  parameter int         ADDR_FILTER    = 0,
  parameter logic [7:0] DEV_ADDR       = 8'h00
) (
  input logic clk,
  input logic nrst,
  ir_cmd_sequencer_if.slave bus
);
  ir_seq_state_t state;
  logic [7:0] f_addr, f_naddr, f_cmd, f_ncmd, nxt_addr, nxt_cmd, rpt_inc;
  logic [7:0] addr_q, cmd_q, rpt_q;
  logic cv_q, press_q, rel_q, hold_q, err_q, active_q;
  logic valid_frame, filter_ok, accepted, same_key, load, expired;
  assign f_addr      = bus.code[IR_ADDR_MSB:IR_ADDR_LSB];
  assign f_naddr     = bus.code[IR_NADDR_MSB:IR_NADDR_LSB];
  assign f_cmd       = bus.code[IR_CMD_MSB:IR_CMD_LSB];
  assign f_ncmd      = bus.code[IR_NCMD_MSB:IR_NCMD_LSB];
  assign valid_frame = (f_addr == ~f_naddr) && (f_cmd == ~f_ncmd);
  assign filter_ok   = (ADDR_FILTER == 0) || (f_addr == DEV_ADDR);
  assign accepted    = bus.newCode && valid_frame && filter_ok;
  assign same_key    = {f_addr, f_cmd} == {addr_q, cmd_q};
  assign rpt_inc     = (rpt_q == 8'hFF) ? rpt_q : rpt_q + 8'd1;
  assign load        = (accepted && (state == IDLE || (state == ACTIVE && same_key))) || state == SWAP;
  ir_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .nrst(nrst), .load(load), .en(state == ACTIVE), .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      addr_q   <= '0;
      cmd_q    <= '0;
      nxt_addr <= '0;
      nxt_cmd  <= '0;
      rpt_q    <= '0;
      cv_q     <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cv_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      err_q   <= bus.newCode && !valid_frame;
      case (state)
        IDLE: if (accepted) begin
          addr_q   <= f_addr;
          cmd_q    <= f_cmd;
          press_q  <= 1'b1;
          cv_q     <= 1'b1;
          rpt_q    <= '0;
          active_q <= 1'b1;
          state    <= ACTIVE;
        end
        ACTIVE: if (accepted && same_key) begin
          rpt_q <= rpt_inc;
          if (int'(rpt_inc) >= HOLD_REPEATS) begin
            hold_q <= 1'b1;
            cv_q   <= 1'b1;
          end
        end else if (accepted) begin
          rel_q    <= 1'b1;
          hold_q   <= 1'b0;
          nxt_addr <= f_addr;
          nxt_cmd  <= f_cmd;
          state    <= SWAP;
        end else if (expired) begin
          rel_q    <= 1'b1;
          hold_q   <= 1'b0;
          active_q <= 1'b0;
          state    <= IDLE;
        end
        SWAP: begin
          addr_q  <= nxt_addr;
          cmd_q   <= nxt_cmd;
          press_q <= 1'b1;
          cv_q    <= 1'b1;
          rpt_q   <= '0;
          state   <= ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.addr        = addr_q;
  assign bus.cmd         = cmd_q;
  assign bus.rpt_count   = rpt_q;
  assign bus.cmd_valid   = cv_q;
  assign bus.press       = press_q;
  assign bus.key_release = rel_q;
  assign bus.hold        = hold_q;
  assign bus.err         = err_q;
  assign bus.active      = active_q;
endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// tb_ir_cmd_sequencer: scenario tasks plus random frames against a key/deadline reference model
module tb_ir_cmd_sequencer;
  localparam int T  = 1000;
  localparam int HR = 3;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ir_cmd_sequencer_if bus();
  ir_cmd_sequencer_if fbus();
  ir_cmd_sequencer #(.TIMEOUT_CYCLES(T), .HOLD_REPEATS(HR), .ADDR_FILTER(0), .DEV_ADDR(8'h00)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );
  ir_cmd_sequencer #(.TIMEOUT_CYCLES(T), .HOLD_REPEATS(HR), .ADDR_FILTER(1), .DEV_ADDR(8'h10)) dut_f (
    .clk(clk), .nrst(nrst), .bus(fbus)
  );
  // model: a key is down until an edge passes its deadline (last accepted frame + T) with nothing accepted
  int cyc = 0;
  int m_rpt = 0;
  int m_deadline = 0;
  bit m_down = 0;
  bit m_swap = 0;
  logic [15:0] m_key = '0;
  logic [15:0] m_next = '0;
  logic e_cv = 0, e_press = 0, e_rel = 0, e_hold = 0, e_err = 0;
  function automatic bit inv_ok(logic [31:0] c);
    return (c[31:24] == ~c[23:16]) && (c[15:8] == ~c[7:0]);
  endfunction
  function automatic logic [29:0] exp_vec();
    return {m_key, 8'(m_rpt), e_cv, e_press, e_rel, e_hold, e_err, m_down};
  endfunction
  function automatic logic [29:0] dut_vec();
    return {bus.addr, bus.cmd, bus.rpt_count, bus.cmd_valid, bus.press, bus.key_release, bus.hold, bus.err, bus.active};
  endfunction
  function automatic logic [29:0] fvec();
    return {fbus.addr, fbus.cmd, fbus.rpt_count, fbus.cmd_valid, fbus.press, fbus.key_release, fbus.hold, fbus.err, fbus.active};
  endfunction
  task automatic start_key(input logic [15:0] k);
    m_key = k;
    e_press = 1;
    e_cv = 1;
    m_rpt = 0;
    m_deadline = cyc + T;
    m_down = 1;
  endtask
  task automatic model_edge(input logic [31:0] c, input logic nc);
    logic ok;
    logic [15:0] k;
    cyc++;
    k = {c[31:24], c[15:8]};
    e_cv = 0; e_press = 0; e_rel = 0;
    if (!nrst) begin
      m_down = 0; m_swap = 0; m_key = '0; m_rpt = 0; e_hold = 0; e_err = 0;
      return;
    end
    e_err = nc && !inv_ok(c);
    ok = nc && inv_ok(c);
    if (m_swap) begin
      m_swap = 0;
      start_key(m_next);
    end else if (!m_down) begin
      if (ok) start_key(k);
    end else if (ok && k == m_key) begin
      if (m_rpt < 255) m_rpt++;
      m_deadline = cyc + T;
      if (m_rpt >= HR) begin e_hold = 1; e_cv = 1; end
    end else if (ok) begin
      e_rel = 1; e_hold = 0; m_next = k; m_swap = 1;
    end else if (cyc == m_deadline) begin
      e_rel = 1; e_hold = 0; m_down = 0;
    end
  endtask
  task automatic tick(input logic [31:0] c, input logic nc);
    bus.code = c;
    bus.newCode = nc;
    model_edge(c, nc);
    @(posedge clk);
    #1;
    bus.newCode = 1'b0;
  endtask
  task automatic test_reset();
    nrst = 1'b0;
    tick(32'h00FF45BA, 1);
    tick(0, 0);
    n_checks++; if (dut_vec() !== 30'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", dut_vec()); end
    n_checks++; if (fvec() !== 30'd0) begin n_fail++; $display("FAIL reset_filter_outputs got=%h exp=0", fvec()); end
    nrst = 1'b1;
    tick(0, 0);
    n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec()); end
  endtask
  task automatic test_single_press();
    int rel_at = -1;
    int rel_n = 0;
    tick(32'h00FF45BA, 1);
    n_checks++;
    if ({bus.press, bus.cmd_valid, bus.cmd, bus.hold} !== {1'b1, 1'b1, 8'h45, 1'b0}) begin
      n_fail++; $display("FAIL single_press got=%b%b %h hold=%b exp=11 45 hold=0", bus.press, bus.cmd_valid, bus.cmd, bus.hold);
    end
    for (int i = 1; i <= 1100; i++) begin
      tick(0, 0);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL single_track cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      if (bus.key_release) begin rel_at = i; rel_n++; end
    end
    n_checks++; if (rel_at != T || rel_n != 1) begin n_fail++; $display("FAIL single_release_time got=%0d(x%0d) exp=%0d(x1)", rel_at, rel_n, T); end
  endtask
  task automatic test_hold();
    int cv_n = 0;
    int rel_at = -1;
    tick(32'h00FF45BA, 1);
    for (int r = 1; r <= 5; r++) begin
      repeat (499) begin
        tick(0, 0);
        n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL hold_gap cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      end
      tick(32'h00FF45BA, 1);
      n_checks++;
      if ({bus.hold, bus.cmd_valid} !== {r >= HR, r >= HR}) begin
        n_fail++; $display("FAIL hold_repeat%0d got=hold%b cv%b exp=hold%b cv%b", r, bus.hold, bus.cmd_valid, r >= HR, r >= HR);
      end
      if (bus.cmd_valid) cv_n++;
    end
    n_checks++; if (bus.rpt_count !== 8'd5 || cv_n != 3) begin n_fail++; $display("FAIL hold_count got=rpt%0d cv%0d exp=rpt5 cv3", bus.rpt_count, cv_n); end
    for (int i = 1; i <= 1100; i++) begin
      tick(0, 0);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL hold_release cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      if (bus.key_release) rel_at = i;
    end
    n_checks++; if (rel_at != T) begin n_fail++; $display("FAIL hold_release_time got=%0d exp=%0d", rel_at, T); end
  endtask
  task automatic test_corrupt();
    int rel_at = -1;
    tick(32'h00FF45BB, 1);
    n_checks++; if ({bus.err, bus.active, bus.press} !== 3'b100) begin n_fail++; $display("FAIL corrupt_idle got=%b exp=100", {bus.err, bus.active, bus.press}); end
    tick(32'h00FF45BA, 1);
    repeat (400) tick(0, 0);
    tick(32'h00FF45BB, 1);
    n_checks++; if ({bus.err, bus.active, bus.rpt_count} !== {2'b11, 8'd0}) begin n_fail++; $display("FAIL corrupt_active got=%b rpt=%0d exp=11 rpt=0", {bus.err, bus.active}, bus.rpt_count); end
    for (int i = 1; i <= 700; i++) begin
      tick(0, 0);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL corrupt_track cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      if (bus.key_release) rel_at = i;
    end
    n_checks++; if (rel_at != T - 401) begin n_fail++; $display("FAIL corrupt_no_reload got=%0d exp=%0d", rel_at, T - 401); end
  endtask
  task automatic test_key_change();
    tick(32'h00FF45BA, 1);
    repeat (3) begin
      repeat (9) tick(0, 0);
      tick(32'h00FF45BA, 1);
    end
    n_checks++; if (bus.hold !== 1'b1) begin n_fail++; $display("FAIL change_pre_hold got=%b exp=1", bus.hold); end
    tick(32'h00FF46B9, 1);
    n_checks++;
    if ({bus.key_release, bus.hold, bus.press, bus.cmd} !== {3'b100, 8'h45}) begin
      n_fail++; $display("FAIL change_release got=%b cmd=%h exp=100 cmd=45", {bus.key_release, bus.hold, bus.press}, bus.cmd);
    end
    tick(0, 0);
    n_checks++;
    if ({bus.press, bus.cmd_valid, bus.key_release, bus.hold, bus.cmd, bus.rpt_count} !== {4'b1100, 8'h46, 8'd0}) begin
      n_fail++; $display("FAIL change_press got=%b cmd=%h rpt=%0d exp=1100 cmd=46 rpt=0", {bus.press, bus.cmd_valid, bus.key_release, bus.hold}, bus.cmd, bus.rpt_count);
    end
    repeat (1100) begin
      tick(0, 0);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL change_track cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
    end
  endtask
  task automatic test_expiry_boundary();
    tick(32'h00FF45BA, 1);
    repeat (T - 1) tick(0, 0);
    tick(32'h00FF45BA, 1);
    n_checks++;
    if ({bus.key_release, bus.active, bus.rpt_count} !== {2'b01, 8'd1}) begin
      n_fail++; $display("FAIL expiry_same_key got=rel%b act%b rpt%0d exp=rel0 act1 rpt1", bus.key_release, bus.active, bus.rpt_count);
    end
    repeat (1100) begin
      tick(0, 0);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL expiry_track cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
    end
  endtask
  task automatic test_reset_mid();
    tick(32'h00FF45BA, 1);
    repeat (3) begin
      repeat (4) tick(0, 0);
      tick(32'h00FF45BA, 1);
    end
    n_checks++; if (bus.hold !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_hold got=%b exp=1", bus.hold); end
    nrst = 1'b0;
    tick(0, 0);
    n_checks++; if (dut_vec() !== 30'd0) begin n_fail++; $display("FAIL midreset_outputs got=%h exp=0", dut_vec()); end
    nrst = 1'b1;
    repeat (3) begin
      tick(0, 0);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL midreset_after cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
    end
  endtask
  task automatic test_saturate();
    tick(32'h00FF45BA, 1);
    repeat (260) begin
      tick(0, 0);
      tick(32'h00FF45BA, 1);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL saturate_track cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
    end
    n_checks++; if ({bus.rpt_count, bus.cmd_valid, bus.hold} !== {8'd255, 2'b11}) begin n_fail++; $display("FAIL saturate_final got=rpt%0d cv%b hold%b exp=rpt255 cv1 hold1", bus.rpt_count, bus.cmd_valid, bus.hold); end
    repeat (1050) begin
      tick(0, 0);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL saturate_release cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
    end
  endtask
  task automatic test_filter();
    fbus.code = 32'h00FF45BA;
    fbus.newCode = 1'b1;
    tick(0, 0);
    fbus.newCode = 1'b0;
    repeat (3) begin
      n_checks++; if (fvec() !== 30'd0) begin n_fail++; $display("FAIL filter_drop got=%h exp=0", fvec()); end
      tick(0, 0);
    end
    fbus.code = 32'h10EF45BA;
    fbus.newCode = 1'b1;
    tick(0, 0);
    fbus.newCode = 1'b0;
    n_checks++;
    if ({fbus.press, fbus.active, fbus.err, fbus.addr, fbus.cmd} !== {3'b110, 8'h10, 8'h45}) begin
      n_fail++; $display("FAIL filter_accept got=%b %h %h exp=110 10 45", {fbus.press, fbus.active, fbus.err}, fbus.addr, fbus.cmd);
    end
  endtask
  task automatic test_random();
    for (int f = 0; f < 50; f++) begin
      int gap;
      logic [7:0] cm;
      logic [31:0] c;
      gap = $urandom_range(2, 1100);
      if ($urandom_range(0, 4) == 0 && m_down && m_deadline - cyc >= 2) gap = m_deadline - cyc;
      cm = 8'h45 + 8'($urandom_range(0, 2));
      c = {8'h00, 8'hFF, cm, ~cm};
      if ($urandom_range(0, 9) == 0) c[0] = ~c[0];
      repeat (gap - 1) begin
        tick(0, 0);
        n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_gap cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      end
      tick(c, 1);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_frame cyc=%0d code=%h got=%h exp=%h", cyc, c, dut_vec(), exp_vec()); end
    end
    repeat (1100) begin
      tick(0, 0);
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
    end
  endtask
  initial begin
    bus.code = '0;
    bus.newCode = 1'b0;
    fbus.code = '0;
    fbus.newCode = 1'b0;
    test_reset();
    test_single_press();
    test_hold();
    test_corrupt();
    test_key_change();
    test_expiry_boundary();
    test_reset_mid();
    test_saturate();
    test_filter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
